pwm_event_scheduler: RTL and testbench

Interrupt scheduler for the eight-carrier PWM block. It takes the per-carrier event pulses (carrier zero/peak events), decimates each channel by its programmed event count, and queues the resulting interrupt requests. A round-robin arbiter then presents the requests one at a time to the processor over a single irq/ack handshake. It sits between the carrier generators and the AXI interrupt line, and replaces per-channel event-edge-clocked masking with one synchronous clock domain.

---
 rtl/pwm_event_scheduler.sv | 127 ++++++++++++
 tb/tb_pwm_event_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_event_scheduler.sv
// Event decimation and round-robin interrupt scheduler for the eight-carrier PWM block.
// Terminal events queue per-channel pending bits that are presented one at a time on irq/irq_ack.
module pwm_event_scheduler #(
    parameter int N_CH           = 8,
    parameter int EVTCOUNT_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pwm_onoff,
    input  logic                           int_onoff,
    input  logic [N_CH-1:0]                ch_enable,
    input  logic [N_CH-1:0]                evt_in,
    input  logic [N_CH*EVTCOUNT_WIDTH-1:0] event_count,
    output logic                           irq,
    output logic [$clog2(N_CH)-1:0]        irq_id,
    input  logic                           irq_ack,
    output logic [N_CH-1:0]                overrun,
    input  logic                           overrun_clr
);

    localparam int W    = EVTCOUNT_WIDTH;
    localparam int ID_W = $clog2(N_CH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]      state;
    logic [W-1:0]    evt_cnt [N_CH];
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] pending_next;
    logic [N_CH-1:0] overrun_next;
    logic [N_CH-1:0] active;
    logic [N_CH-1:0] term;
    logic [N_CH-1:0] granted;
    logic [N_CH-1:0] ack_clr;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic [ID_W:0]   search_idx;

    assign irq = (state == BUSY);

    // A set from a terminal event always beats a clear (ack or overrun_clr) in the same cycle.
    always_comb begin
        active       = '0;
        term         = '0;
        granted      = '0;
        ack_clr      = '0;
        pending_next = '0;
        overrun_next = '0;
        for (int i = 0; i < N_CH; i++) begin
            active[i]  = pwm_onoff & ch_enable[i];
            granted[i] = (state == BUSY) && (irq_id == ID_W'(i));
            ack_clr[i] = granted[i] & irq_ack;
            term[i]    = evt_in[i] & active[i] & (evt_cnt[i] >= event_count[i*W +: W]);
            if (!active[i]) begin
                pending_next[i] = pending[i] & granted[i] & ~ack_clr[i];
            end else if (term[i]) begin
                pending_next[i] = 1'b1;
            end else begin
                pending_next[i] = pending[i] & ~ack_clr[i];
            end
            overrun_next[i] = (overrun[i] & ~overrun_clr) | (term[i] & pending[i] & ~ack_clr[i]);
        end
    end

    // First pending channel at or above rr_ptr, wrapping past the top channel.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        search_idx  = '0;
        for (int j = 0; j < N_CH; j++) begin
            search_idx = {1'b0, rr_ptr} + (ID_W+1)'(j);
            if (search_idx >= (ID_W+1)'(N_CH)) begin
                search_idx = search_idx - (ID_W+1)'(N_CH);
            end
            if (!grant_found && pending[search_idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = search_idx[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                evt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (!active[i]) begin
                    evt_cnt[i] <= '0;
                end else if (evt_in[i]) begin
                    evt_cnt[i] <= term[i] ? '0 : evt_cnt[i] + W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            irq_id  <= '0;
            rr_ptr  <= '0;
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= pending_next;
            overrun <= overrun_next;
            case (state)
                IDLE: begin
                    if (int_onoff && grant_found) begin
                        state  <= BUSY;
                        irq_id <= grant_idx;
                    end
                end
                default: begin
                    if (irq_ack) begin
                        state  <= IDLE;
                        rr_ptr <= (irq_id == ID_W'(N_CH-1)) ? '0 : irq_id + ID_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_event_scheduler.sv
// Directed bench for pwm_event_scheduler: a cycle table for decimation plus hand sequences
// for arbitration order, overrun, ack/event collision, enables and asynchronous reset.
module tb_pwm_event_scheduler;

    localparam int N_CH = 8;
    localparam int W    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              pwm_onoff;
    logic              int_onoff;
    logic [N_CH-1:0]   ch_enable;
    logic [N_CH-1:0]   evt_in;
    logic [N_CH*W-1:0] event_count;
    logic              irq;
    logic [2:0]        irq_id;
    logic              irq_ack;
    logic [N_CH-1:0]   overrun;
    logic              overrun_clr;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_event_scheduler #(.N_CH(N_CH), .EVTCOUNT_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .pwm_onoff(pwm_onoff), .int_onoff(int_onoff),
        .ch_enable(ch_enable), .evt_in(evt_in), .event_count(event_count),
        .irq(irq), .irq_id(irq_id), .irq_ack(irq_ack),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       evt;
        logic       ack;
        logic       exp_irq;
        logic [2:0] exp_id;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a falling edge; applies inputs across one rising edge and returns at the next falling edge.
    task automatic step(input logic [N_CH-1:0] e, input logic a);
        evt_in  = e;
        irq_ack = a;
        @(posedge clk);
        @(negedge clk);
        evt_in  = '0;
        irq_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic expect_grant(input string name, input int id);
        check({name, "_irq"}, int'(irq), 1);
        check({name, "_id"}, int'(irq_id), id);
        step('0, 1'b1);
        check({name, "_ackdrop"}, int'(irq), 0);
    endtask

    initial begin
        reset       = 1'b0;
        pwm_onoff   = 1'b1;
        int_onoff   = 1'b1;
        ch_enable   = '1;
        evt_in      = '0;
        event_count = '0;
        irq_ack     = 1'b0;
        overrun_clr = 1'b0;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 3'd2};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 3'd0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'd0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 3'd0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 3'd0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 3'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 3'd2};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 3'd0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 3'd0};

        @(negedge clk);
        check("reset_irq", int'(irq), 0);
        check("reset_id", int'(irq_id), 0);
        check("reset_overrun", int'(overrun), 0);
        reset = 1'b1;

        // Decimation by 4 on channel 2
        event_count[2*W +: W] = 4'd3;
        for (int k = 0; k < 13; k++) begin
            step(tbl[k].evt ? 8'h04 : 8'h00, tbl[k].ack);
            check($sformatf("decim_irq_%0d", k), int'(irq), int'(tbl[k].exp_irq));
            if (tbl[k].exp_irq) check($sformatf("decim_id_%0d", k), int'(irq_id), int'(tbl[k].exp_id));
        end
        check("decim_overrun", int'(overrun), 0);

        // Round-robin order
        event_count = '0;
        do_reset();
        step(8'b0110_0010, 1'b0);
        check("rr_latency", int'(irq), 0);
        step('0, 1'b0);
        expect_grant("rr_a1", 1);
        step('0, 1'b0);
        expect_grant("rr_a5", 5);
        step('0, 1'b0);
        expect_grant("rr_a6", 6);
        step(8'h20, 1'b0);
        step('0, 1'b0);
        expect_grant("rr_set5", 5);
        step(8'b0100_0010, 1'b0);
        step('0, 1'b0);
        expect_grant("rr_b6", 6);
        step('0, 1'b0);
        expect_grant("rr_b1", 1);

        // Overrun on channel 0
        do_reset();
        step(8'h01, 1'b0);
        step(8'h01, 1'b0);
        check("ovr_irq", int'(irq), 1);
        check("ovr_id", int'(irq_id), 0);
        check("ovr_flag", int'(overrun), 1);
        step('0, 1'b0);
        check("ovr_hold", int'(irq), 1);
        step('0, 1'b1);
        check("ovr_ackdrop", int'(irq), 0);
        step('0, 1'b0);
        check("ovr_pending_clear", int'(irq), 0);
        check("ovr_sticky", int'(overrun), 1);
        overrun_clr = 1'b1;
        step('0, 1'b0);
        overrun_clr = 1'b0;
        check("ovr_clr", int'(overrun), 0);

        // Terminal event on the granted channel in its ack cycle
        do_reset();
        step(8'h08, 1'b0);
        step('0, 1'b0);
        check("coll_irq", int'(irq), 1);
        check("coll_id", int'(irq_id), 3);
        step(8'h08, 1'b1);
        check("coll_gap", int'(irq), 0);
        check("coll_no_ovr", int'(overrun), 0);
        step('0, 1'b0);
        expect_grant("coll_regrant", 3);

        // Interrupt enable and channel enable
        do_reset();
        int_onoff = 1'b0;
        step(8'h10, 1'b0);
        step('0, 1'b0);
        check("inten_block1", int'(irq), 0);
        step('0, 1'b0);
        check("inten_block2", int'(irq), 0);
        int_onoff = 1'b1;
        step('0, 1'b0);
        expect_grant("inten_grant", 4);
        int_onoff = 1'b0;
        step(8'h10, 1'b0);
        ch_enable[4] = 1'b0;
        step('0, 1'b0);
        ch_enable[4] = 1'b1;
        int_onoff = 1'b1;
        step('0, 1'b0);
        check("chen_clear1", int'(irq), 0);
        step('0, 1'b0);
        check("chen_clear2", int'(irq), 0);

        // Asynchronous reset mid-interrupt
        do_reset();
        event_count[7*W +: W] = 4'd1;
        step(8'h81, 1'b0);
        step(8'h01, 1'b0);
        check("arst_pre_irq", int'(irq), 1);
        check("arst_pre_ovr", int'(overrun), 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_irq", int'(irq), 0);
        check("arst_ovr", int'(overrun), 0);
        check("arst_id", int'(irq_id), 0);
        @(negedge clk);
        reset = 1'b1;
        step(8'h80, 1'b0);
        step('0, 1'b0);
        check("arst_cnt_first", int'(irq), 0);
        step(8'h80, 1'b0);
        step('0, 1'b0);
        check("arst_cnt_second", int'(irq), 1);
        check("arst_cnt_id", int'(irq_id), 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
